// File: rtl/uart_echo_buf.sv
// Receive-to-transmit echo buffer: a FIFO drained one byte at a time into a UART transmitter.
// Define UART_ECHO_UPPER_EN to fold lowercase ASCII to uppercase as bytes enter the FIFO.
module uart_echo_buf #(
  parameter int DATA_W = 8,
  parameter int DEPTH = 16,
  parameter int LINE_MODE = 0,
  parameter logic [DATA_W-1:0] EOL_CHAR = 8'h0D
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DATA_W-1:0]        rx_data,
  input  logic                     rx_valid,
  input  logic                     tx_busy,
  output logic [DATA_W-1:0]        tx_data,
  output logic                     tx_start,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  output logic                     flushing
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam logic [LVL_W-1:0] FULL = LVL_W'(DEPTH);

  typedef enum logic [1:0] {IDLE, START, WAIT_BUSY, WAIT_DONE} state_t;

  state_t              state_reg, state_next;
  logic [DATA_W-1:0]   mem [DEPTH];
  logic [PTR_W-1:0]    wr_ptr_reg, rd_ptr_reg;
  logic [LVL_W-1:0]    level_reg, level_next;
  logic                overflow_reg;
  logic [DATA_W-1:0]   tx_data_reg;
  logic [DATA_W-1:0]   wr_data;
  logic                push, pop, drop, go, flushing_int;

`ifdef UART_ECHO_UPPER_EN
  always_comb begin
    wr_data = rx_data;
    if (rx_data >= DATA_W'(8'h61) && rx_data <= DATA_W'(8'h7A))
      wr_data = rx_data - DATA_W'(8'h20);
  end
`else
  assign wr_data = rx_data;
`endif

  // A full FIFO drops the byte even if a pop frees a slot in the same cycle.
  assign push = rx_valid && (level_reg != FULL);
  assign drop = rx_valid && (level_reg == FULL);
  assign pop  = (state_reg == START);
  assign go   = flushing_int && (level_reg != '0) && !tx_busy;

  always_comb begin
    level_next = level_reg;
    if (push && !pop)
      level_next = level_reg + 1'b1;
    else if (!push && pop)
      level_next = level_reg - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (push && !rst)
      mem[wr_ptr_reg] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      level_reg    <= '0;
      overflow_reg <= 1'b0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      level_reg <= level_next;
      if (drop) overflow_reg <= 1'b1;
    end
  end

  // Head is fetched on entry to START so tx_data is already stable when tx_start rises.
  always_ff @(posedge clk) begin
    if (rst)
      tx_data_reg <= '0;
    else if (state_reg == IDLE && go)
      tx_data_reg <= mem[rd_ptr_reg];
  end

  generate
    if (LINE_MODE == 0) begin : g_immediate
      assign flushing_int = (level_reg != '0);
    end else begin : g_line
      logic flush_reg;
      always_ff @(posedge clk) begin
        if (rst)
          flush_reg <= 1'b0;
        else if ((push && wr_data == EOL_CHAR) || level_next == FULL)
          flush_reg <= 1'b1;
        else if (level_next == '0)
          flush_reg <= 1'b0;
      end
      assign flushing_int = flush_reg;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst)
      state_reg <= IDLE;
    else
      state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:      if (go) state_next = START;
      START:     state_next = WAIT_BUSY;
      WAIT_BUSY: if (tx_busy) state_next = WAIT_DONE;
      WAIT_DONE: if (!tx_busy) state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  assign tx_start = (state_reg == START);
  assign tx_data  = tx_data_reg;
  assign level    = level_reg;
  assign overflow = overflow_reg;
  assign flushing = flushing_int;

endmodule

// File: tb/tb_uart_echo_buf.sv
// Directed bench: an immediate-echo instance and a line-buffered instance, each with a
// transmitter model that stays busy for 10 cycles after every tx_start.
module tb_uart_echo_buf;

  logic       clk, rst;
  logic [7:0] rx_data0, rx_data1, txd0, txd1;
  logic       rx_valid0, rx_valid1, busy0, busy1, txs0, txs1;
  logic       ovf0, ovf1, fl0, fl1, hold0;
  logic [4:0] level0, level1;
  int         cnt0, cnt1;
  int         tests_run, fail_count;
  logic [7:0] q0[$];
  logic [7:0] q1[$];
  logic       found;

  uart_echo_buf #(.DATA_W(8), .DEPTH(16), .LINE_MODE(0), .EOL_CHAR(8'h0D)) dut0 (
    .clk(clk), .rst(rst), .rx_data(rx_data0), .rx_valid(rx_valid0), .tx_busy(busy0),
    .tx_data(txd0), .tx_start(txs0), .level(level0), .overflow(ovf0), .flushing(fl0)
  );

  uart_echo_buf #(.DATA_W(8), .DEPTH(16), .LINE_MODE(1), .EOL_CHAR(8'h0D)) dut1 (
    .clk(clk), .rst(rst), .rx_data(rx_data1), .rx_valid(rx_valid1), .tx_busy(busy1),
    .tx_data(txd1), .tx_start(txs1), .level(level1), .overflow(ovf1), .flushing(fl1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst) cnt0 <= 0;
    else if (txs0) cnt0 <= 10;
    else if (cnt0 != 0) cnt0 <= cnt0 - 1;
  end
  always @(posedge clk) begin
    if (rst) cnt1 <= 0;
    else if (txs1) cnt1 <= 10;
    else if (cnt1 != 0) cnt1 <= cnt1 - 1;
  end
  assign busy0 = hold0 || (cnt0 != 0);
  assign busy1 = (cnt1 != 0);

  // START lasts exactly one cycle, so one negedge sample per transmitted byte.
  always @(negedge clk) begin
    if (txs0) q0.push_back(txd0);
    if (txs1) q1.push_back(txd1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      fail_count++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end else begin
      $display("[TB] ok %s = %0h", tag, got);
    end
  endtask

  function automatic logic [7:0] up(input logic [7:0] b);
`ifdef UART_ECHO_UPPER_EN
    if (b >= 8'h61 && b <= 8'h7A) return b - 8'h20;
`endif
    return b;
  endfunction

  task automatic send0(input logic [7:0] b);
    rx_data0 = b; rx_valid0 = 1'b1;
    @(negedge clk);
    rx_valid0 = 1'b0;
  endtask

  task automatic send1(input logic [7:0] b);
    rx_data1 = b; rx_valid1 = 1'b1;
    @(negedge clk);
    rx_valid1 = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [31:0] q0_at(input int i);
    if (i < q0.size()) return 32'(q0[i]);
    return 32'hDEAD;
  endfunction

  function automatic logic [31:0] q1_at(input int i);
    if (i < q1.size()) return 32'(q1[i]);
    return 32'hDEAD;
  endfunction

  initial begin
    tests_run = 0; fail_count = 0;
    rst = 1'b1; hold0 = 1'b0;
    rx_data0 = 8'h00; rx_valid0 = 1'b0;
    rx_data1 = 8'h00; rx_valid1 = 1'b0;
    idle(3);
    check("rst_level", 32'(level0), 32'd0);
    check("rst_overflow", 32'(ovf0), 32'd0);
    check("rst_flushing", 32'(fl0), 32'd0);
    check("rst_tx_start", 32'(txs0), 32'd0);
    check("rst_tx_data", 32'(txd0), 32'd0);
    check("rst_flushing_line", 32'(fl1), 32'd0);
    rst = 1'b0;
    idle(2);

    // Immediate echo of one byte, with n+2 latency
    send0(8'h41);
    check("t1_level_after_write", 32'(level0), 32'd1);
    check("t1_no_start_yet", 32'(txs0), 32'd0);
    idle(1);
    check("t1_tx_start", 32'(txs0), 32'd1);
    check("t1_tx_data", 32'(txd0), 32'h41);
    idle(30);
    check("t1_echo_count", 32'(q0.size()), 32'd1);
    check("t1_echo_byte", q0_at(0), 32'h41);
    check("t1_level_empty", 32'(level0), 32'd0);
    check("t1_tx_data_held", 32'(txd0), 32'h41);
    check("t1_flushing_off", 32'(fl0), 32'd0);

    // Line mode: nothing leaves until EOL
    q1.delete();
    send1(8'h61); send1(8'h62); send1(8'h63);
    idle(5);
    check("t2_no_echo_before_eol", 32'(q1.size()), 32'd0);
    check("t2_flushing_low", 32'(fl1), 32'd0);
    check("t2_level3", 32'(level1), 32'd3);
    send1(8'h0D);
    check("t2_flushing_set", 32'(fl1), 32'd1);
    idle(80);
    check("t2_echo_count", 32'(q1.size()), 32'd4);
    check("t2_echo0", q1_at(0), 32'(up(8'h61)));
    check("t2_echo1", q1_at(1), 32'(up(8'h62)));
    check("t2_echo2", q1_at(2), 32'(up(8'h63)));
    check("t2_echo3", q1_at(3), 32'h0D);
    check("t2_flushing_cleared", 32'(fl1), 32'd0);
    check("t2_level_empty", 32'(level1), 32'd0);

    // Line mode: filling the FIFO without EOL forces a flush
    q1.delete();
    for (int i = 0; i < 15; i++) send1(8'h78);
    check("t4_flushing_low_at15", 32'(fl1), 32'd0);
    check("t4_level15", 32'(level1), 32'd15);
    send1(8'h78);
    check("t4_level16", 32'(level1), 32'd16);
    check("t4_flushing_full", 32'(fl1), 32'd1);
    idle(260);
    check("t4_echo_count", 32'(q1.size()), 32'd16);
    for (int i = 0; i < 16; i++) check($sformatf("t4_echo%0d", i), q1_at(i), 32'(up(8'h78)));
    check("t4_flushing_cleared", 32'(fl1), 32'd0);
    check("t4_level_empty", 32'(level1), 32'd0);
    check("t4_no_overflow", 32'(ovf1), 32'd0);

    // Overflow: transmitter held busy, 17 writes
    q0.delete();
    hold0 = 1'b1;
    for (int i = 0; i < 16; i++) send0(8'(8'h30 + i));
    check("t3_level16", 32'(level0), 32'd16);
    check("t3_no_overflow_at16", 32'(ovf0), 32'd0);
    send0(8'h40);
    check("t3_level_still16", 32'(level0), 32'd16);
    check("t3_overflow_set", 32'(ovf0), 32'd1);
    hold0 = 1'b0;
    idle(260);
    check("t3_echo_count", 32'(q0.size()), 32'd16);
    for (int i = 0; i < 16; i++) check($sformatf("t3_echo%0d", i), q0_at(i), 32'h30 + 32'(i));
    check("t3_overflow_sticky", 32'(ovf0), 32'd1);
    check("t3_level_empty", 32'(level0), 32'd0);

    // Reset during WAIT_BUSY with 5 bytes still queued, rx_valid also high
    q0.delete();
    hold0 = 1'b1;
    for (int i = 0; i < 6; i++) send0(8'(8'h41 + i));
    check("t5_level6", 32'(level0), 32'd6);
    hold0 = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      found = txs0;
    end
    check("t5_start_seen", 32'(found), 32'd1);
    idle(1);
    check("t5_level5_wait_busy", 32'(level0), 32'd5);
    rst = 1'b1; rx_data0 = 8'h7E; rx_valid0 = 1'b1;
    idle(1);
    check("t5_level_cleared", 32'(level0), 32'd0);
    check("t5_tx_start_low", 32'(txs0), 32'd0);
    check("t5_overflow_cleared", 32'(ovf0), 32'd0);
    check("t5_flushing_low", 32'(fl0), 32'd0);
    check("t5_tx_data_cleared", 32'(txd0), 32'd0);
    rst = 1'b0; rx_valid0 = 1'b0;
    q0.delete();
    idle(30);
    check("t5_nothing_sent_after_rst", 32'(q0.size()), 32'd0);
    check("t5_level_still_empty", 32'(level0), 32'd0);

    // Push and pop together at DEPTH-1, write pointer wraps
    q0.delete();
    hold0 = 1'b1;
    for (int i = 0; i < 15; i++) send0(8'(8'h50 + i));
    check("t6_level15", 32'(level0), 32'd15);
    hold0 = 1'b0;
    idle(1);
    check("t6_in_start", 32'(txs0), 32'd1);
    send0(8'h5F);
    check("t6_level_unchanged", 32'(level0), 32'd15);
    send0(8'h60);
    check("t6_level16", 32'(level0), 32'd16);
    idle(300);
    check("t6_echo_count", 32'(q0.size()), 32'd17);
    for (int i = 0; i < 17; i++) check($sformatf("t6_echo%0d", i), q0_at(i), 32'h50 + 32'(i));
    check("t6_level_empty", 32'(level0), 32'd0);
    check("t6_no_overflow", 32'(ovf0), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, fail_count);
    $finish;
  end

endmodule
